regfile_param: RTL
==================

Name: regfile_param

Overview:
- Parametrised multi-register file: DEPTH registers of WIDTH bits each, one write port and two independent read ports.
- Successor to the single fixed 32-bit enable register; replaces banks of hand-instantiated registers in the processor datapath.
- Used as the architectural register file feeding the ALU operand muxes.
- Optional hardwired-zero register 0 and optional write-to-read bypass.

Parameters:
- WIDTH, 32, bits per register.
- DEPTH, 32, number of registers; any value 2..256, not required to be a power of two.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden by instantiators.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero; 0 = register 0 is ordinary storage.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; clears every register.
- we  input  1  write enable for the write port.
- waddr  input  ADDR_W  write address.
- wdata  input  WIDTH  write data.
- raddr_a  input  ADDR_W  read port A address.
- rdata_a  output  WIDTH  read port A data.
- raddr_b  input  ADDR_W  read port B address.
- rdata_b  output  WIDTH  read port B data.
- wr_count  output  16  saturating count of committed writes since reset.

Behaviour:
- Storage: DEPTH x WIDTH flops, updated only on the rising edge of clock.
- Reset:
  - reset=1 at an edge clears all registers and wr_count to 0.
  - Reset has priority over a write in the same cycle; the write is discarded.
  - Reset asserted mid-sequence takes effect at the next edge only, because it is synchronous.
- Write commit: if we=1, reset=0 and waddr<DEPTH at an edge, then reg[waddr]<=wdata.
  - No effect if waddr>=DEPTH.
  - No effect if ZERO_REG=1 and waddr==0.
- wr_count:
  - Increments by 1 on each committed write only; discarded writes (bad address, reg0 with ZERO_REG, during reset) do not count.
  - Saturates at 16'hFFFF with no wrap-around.
  - Reset value 0.
- Reads:
  - Combinational, zero-cycle latency: rdata_x = reg[raddr_x].
  - raddr_x>=DEPTH returns all zeros.
  - ZERO_REG=1 and raddr_x==0 returns all zeros regardless of storage.
- Read-after-write, bypass disabled: a read of waddr in the write cycle returns the old value; the new value is visible from the cycle after the edge.
- Both ports may read the same address in the same cycle; both return identical data.
- Outputs during reset: rdata_a and rdata_b reflect storage, i.e. all zeros from the first edge with reset=1 onward.
- No X propagation: every output is defined from the first reset edge.
- No handshake; write is accepted every cycle that we=1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass on each read port.
  - If we=1, reset=0, waddr<DEPTH, raddr_x==waddr and the target is writable, rdata_x=wdata combinationally in the same cycle.
  - Bypass never applies to hardwired reg0 or out-of-range addresses.
  - Bypass is suppressed while reset=1.
- Undefined: no bypass path; read-after-write follows the one-cycle rule in Behaviour.
- Storage, wr_count and reset behaviour are identical in both builds.

Test Plan:
- Reset clears: write 32'hDEADBEEF to reg5, then assert reset for 1 cycle -> rdata_a at raddr_a=5 reads 0; wr_count=0.
- Basic write/read: write reg3=32'h12345678 and reg7=32'hCAFEF00D on consecutive cycles, then raddr_a=3, raddr_b=7 -> rdata_a=32'h12345678, rdata_b=32'hCAFEF00D; wr_count=2.
- Zero register, ZERO_REG=1: write reg0=32'hFFFFFFFF -> rdata_a at addr 0 reads 0 and wr_count is unchanged. Repeat with ZERO_REG=0 -> reads 32'hFFFFFFFF.
- Same-cycle RAW: reg9 holds 32'h1; in one cycle write reg9=32'h2 while raddr_a=9.
  - Without REGFILE_BYPASS_EN -> rdata_a=32'h1, then 32'h2 next cycle.
  - With REGFILE_BYPASS_EN -> rdata_a=32'h2 in the same cycle.
- Reset vs write collision plus out-of-range: DEPTH=20; write reg4=32'hA5A5A5A5 with reset=1 in the same cycle -> reg4 reads 0. Write waddr=25 -> no change, wr_count unchanged; raddr_b=25 -> rdata_b=0.
- Counter saturation: force 65 540 committed writes -> wr_count holds 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file: DEPTH x WIDTH, one write port, two combinational read ports,
// optional hardwired-zero register 0 and optional write-through bypass (macro REGFILE_BYPASS_EN).
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic [15:0]       wr_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [15:0]      r_count;
    logic             w_wr_ok;
    logic [ADDR_W-1:0] w_raddr [2];

    // A write commits only to an in-range, writable register outside reset.
    assign w_wr_ok = we && !reset && (32'(waddr) < DEPTH)
                     && !((ZERO_REG != 0) && (waddr == '0));

    assign w_raddr[0] = raddr_a;
    assign w_raddr[1] = raddr_b;

    // NOTE: the whole array is cleared on reset because every read must be defined from the
    // first reset edge; sequential state is assigned with <= so all flops see pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_count <= '0;
        end else if (w_wr_ok) begin
            r_mem[waddr] <= wdata;
            if (r_count != 16'hFFFF) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [WIDTH-1:0] w_data;
        logic             w_hit;

        // NOTE: every always_comb output gets a default first so no latch is inferred.
        always_comb begin
            w_data = '0;
            w_hit  = 1'b0;
`ifdef REGFILE_BYPASS_EN
            w_hit  = w_wr_ok && (w_raddr[p] == waddr);
`endif
            if ((32'(w_raddr[p]) < DEPTH) && !((ZERO_REG != 0) && (w_raddr[p] == '0))) begin
                w_data = w_hit ? wdata : r_mem[w_raddr[p]];
            end
        end
    end

    assign rdata_a  = g_rd[0].w_data;
    assign rdata_b  = g_rd[1].w_data;
    assign wr_count = r_count;

endmodule
